tile_sprite_renderer: RTL and testbench
=======================================

# tile_sprite_renderer

Pipelined pixel-colour generator for the VGA path. For every active pixel it looks up a tile code in an external map RAM, converts the code to a 12-bit colour, and composites up to NUM_SPRITES fixed-size sprites over that colour, taking sprite pixels from an external sprite ROM. It sits between the VGA timing generator (row/col/pix_valid) and the DAC output registers. It adds horizontal scrolling and frame-latched sprite positions, so game logic can update them at any time without tearing.

## Interface
- SCREEN_WIDTH, 640, active columns
- SCREEN_HEIGHT, 480, active rows
- TILE_W, 40, tile edge in pixels (square tiles)
- MAP_ROWS, 12, tile rows in map RAM
- MAP_COLS, 17, tile columns in map RAM (world width = MAP_COLS*TILE_W)
- NUM_SPRITES, 4, sprite slots, 1..8
- SPRITE_W, 42, sprite edge in pixels (square)
- clk  in  1  pixel clock; single clock domain
- reset_n  in  1  synchronous, active-low reset
- pix_valid  in  1  row/col is an active pixel
- row, col  in  10 each  screen coordinates, unsigned
- frame_start  in  1  one-cycle pulse at start of vertical blank
- scroll_x  in  10  world x-offset, latched on frame_start
- sprite_en  in  NUM_SPRITES  per-slot enable, latched on frame_start
- sprite_x, sprite_y  in  10*NUM_SPRITES each  packed screen top-left positions, slot i at [10i+9:10i], latched on frame_start
- map_addr  out  $clog2(MAP_ROWS*MAP_COLS)  tile_row*MAP_COLS + tile_col
- map_data  in  8  tile code, valid the cycle after map_addr
- spr_addr  out  $clog2(NUM_SPRITES)+2*$clog2(SPRITE_W)  {slot, v, u}
- spr_data  in  13  {opaque, r[3:0], g[3:0], b[3:0]}, valid the cycle after spr_addr
- red, green, blue  out  4 each  registered pixel colour
- out_valid  out  1  red/green/blue belong to an active pixel

## Operation
- Frame registers: on frame_start, capture scroll_x, sprite_en, sprite_x and sprite_y. They hold for the whole frame.
- World x: wx = (col + scroll_q) mod (MAP_COLS*TILE_W). Compute it with an 11-bit sum and a single conditional subtract; scroll_q < world width is required.
- Tile: tile_col = wx / TILE_W, tile_row = row / TILE_W. If row >= MAP_ROWS*TILE_W, the pixel is forced to code 0.
- Palette: 0 border 0/0/0; 1 sky 0/9/F; 2 block 8/4/3; 3 ground 0/F/2; 4 token sky colour, except tile-local x and y both in [TILE_W/4, 3*TILE_W/4) give gold F/C/0; any other code 0/0/0.
- Sprite hit, slot i: enabled, col in [x_i, x_i+SPRITE_W-1], row in [y_i, y_i+SPRITE_W-1]. Sprites use screen coordinates and ignore scroll. The lowest-index hitting slot wins, and only that slot is fetched: u = col−x_i, v = row−y_i.
- Composite: if a slot hit and spr_data.opaque = 1, output the sprite colour. Otherwise output the palette colour. A transparent top sprite does not reveal lower sprites.
- Blanking: if pix_valid = 0, the pixel emerges with out_valid = 0 and RGB = 0.

## Timing
- Pipeline stages:
  - Edge E samples pix_valid/row/col and registers map_addr, spr_addr and the hit/slot state.
  - Memories return data after E+1.
  - Edge E+2 registers the palette colour, sprite colour and opaque flag.
  - Edge E+3 updates red/green/blue and out_valid.
- Latency is exactly 3 cycles. Throughput is 1 pixel per cycle, with no stalls.
- frame_start at edge E: pixels sampled at E use the old frame registers; pixels sampled from E+1 onward use the new values.
- Reset (reset_n low at an edge): the outputs below are zero from the next edge, and in-flight pixels are discarded.
  - red, green, blue, out_valid, map_addr, spr_addr
  - scroll_q, sprite_en_q, sprite positions
  - all pipeline valid bits
- After reset_n rises, the first out_valid comes 3 cycles after the first sampled pix_valid.
- Scroll wrap: col + scroll_q ≥ world width wraps to tile column 0 in the same cycle, with no extra latency.

## Configuration
- TILE_RENDERER_SCROLL_EN defined: scroll_x is latched and applied as above.
- TILE_RENDERER_SCROLL_EN undefined:
  - The scroll register and adder are removed, and wx = col.
  - scroll_x is ignored.
  - All other behaviour is unchanged.

## Test plan
- Reset: hold reset_n low 4 cycles while streaming pixels -> all outputs 0. Release, then drive pix_valid at (0,0) with map code 1 -> out_valid = 1 and RGB 0/9/F exactly 3 cycles later.
- Palette/token: code 4 at tile (0,0). Pixel (5,5) -> 0/9/F. Pixel (20,20) -> F/C/0. Code 9 -> 0/0/0. Row 480 with pix_valid = 0 -> out_valid = 0, RGB 0.
- Scroll wrap (macro on): scroll_x = 660 latched by frame_start. Col 20 -> map_addr column 0 (wx = 0). Col 0 -> column 16. Changing scroll_x mid-frame without frame_start -> no effect.
- Sprite priority: slots 0 and 2 both cover (100,100). Slot 0 opaque red F/0/0 -> output F/0/0. Slot 0 transparent -> tile colour, not slot 2.
- Frame latching: pulse frame_start at the same edge as pixel P with new sprite_x -> P rendered with old position, next pixel with new.
- Macro off: scroll_x = 40 with frame_start -> col 0 still addresses tile column 0.

Source files
------------

// File: rtl/tile_sprite_renderer_if.sv
// Pixel, memory and colour-output signals of tile_sprite_renderer.
// master = renderer view, slave = timing generator / memories / DAC view.
interface tile_sprite_renderer_if #(
  parameter int NUM_SPRITES = 4,
  parameter int MAP_ADDR_W  = 8,
  parameter int SPR_ADDR_W  = 14
);
  logic                      pix_valid;
  logic [9:0]                row;
  logic [9:0]                col;
  logic                      frame_start;
  logic [9:0]                scroll_x;
  logic [NUM_SPRITES-1:0]    sprite_en;
  logic [10*NUM_SPRITES-1:0] sprite_x;
  logic [10*NUM_SPRITES-1:0] sprite_y;
  logic [MAP_ADDR_W-1:0]     map_addr;
  logic [7:0]                map_data;
  logic [SPR_ADDR_W-1:0]     spr_addr;
  logic [12:0]               spr_data;
  logic [3:0]                red;
  logic [3:0]                green;
  logic [3:0]                blue;
  logic                      out_valid;

  modport master (
    input  pix_valid, row, col, frame_start, scroll_x, sprite_en, sprite_x, sprite_y,
    input  map_data, spr_data,
    output map_addr, spr_addr, red, green, blue, out_valid
  );

  modport slave (
    output pix_valid, row, col, frame_start, scroll_x, sprite_en, sprite_x, sprite_y,
    output map_data, spr_data,
    input  map_addr, spr_addr, red, green, blue, out_valid
  );
endinterface

// File: rtl/tile_sprite_renderer.sv
// Tile-map + sprite pixel colour pipeline, 3-cycle latency, 1 pixel/clock.
// Define TILE_RENDERER_SCROLL_EN to enable the frame-latched horizontal scroll.
module tile_sprite_renderer #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int TILE_W        = 40,
  parameter int MAP_ROWS      = 12,
  parameter int MAP_COLS      = 17,
  parameter int NUM_SPRITES   = 4,
  parameter int SPRITE_W      = 42
) (
  input logic                   clk,
  input logic                   reset_n,
  tile_sprite_renderer_if.master bus
);
  localparam int MAP_ADDR_W = $clog2(MAP_ROWS * MAP_COLS);
  localparam int UV_W       = $clog2(SPRITE_W);
  localparam int SLOT_W     = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

  localparam logic [10:0] WORLD_W = 11'(MAP_COLS * TILE_W);
  localparam logic [10:0] MAP_H   = 11'(MAP_ROWS * TILE_W);
  localparam logic [10:0] TW      = 11'(TILE_W);
  localparam logic [10:0] MC      = 11'(MAP_COLS);
  localparam logic [10:0] TOK_LO  = 11'(TILE_W / 4);
  localparam logic [10:0] TOK_HI  = 11'(3 * TILE_W / 4);
  localparam logic [10:0] SW      = 11'(SPRITE_W);
  localparam bit unused_screen_dims = (SCREEN_WIDTH > 0) && (SCREEN_HEIGHT > 0);

  logic [NUM_SPRITES-1:0]    sprite_en_q;
  logic [10*NUM_SPRITES-1:0] sprite_x_q;
  logic [10*NUM_SPRITES-1:0] sprite_y_q;

  logic [10:0] row_w, wx, tile_col, tile_row, lx, ly, dx, dy;
  logic        oob_c, inner_c, hit_c;
  logic [MAP_ADDR_W-1:0] map_addr_c;
  logic [SLOT_W-1:0]     slot_c;
  logic [UV_W-1:0]       u_c, v_c;

  logic        v1, oob1, inner1, hit1;
  logic        v2, oob2, inner2, hit2;
  logic        v3, opq3;
  logic [11:0] pal_c, pal3, spr3;

`ifdef TILE_RENDERER_SCROLL_EN
  logic [9:0]  scroll_q;
  logic [10:0] wx_sum;

  always_ff @(posedge clk) begin
    if (!reset_n)             scroll_q <= '0;
    else if (bus.frame_start) scroll_q <= bus.scroll_x;
  end

  // scroll_q < world width keeps the sum below 2*WORLD_W, so one subtract wraps it.
  always_comb begin
    wx_sum = {1'b0, bus.col} + {1'b0, scroll_q};
    wx     = (wx_sum >= WORLD_W) ? wx_sum - WORLD_W : wx_sum;
  end
`else
  logic unused_scroll;
  assign unused_scroll = ^bus.scroll_x;
  assign wx = {1'b0, bus.col};
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sprite_en_q <= '0;
      sprite_x_q  <= '0;
      sprite_y_q  <= '0;
    end else if (bus.frame_start) begin
      sprite_en_q <= bus.sprite_en;
      sprite_x_q  <= bus.sprite_x;
      sprite_y_q  <= bus.sprite_y;
    end
  end

  always_comb begin
    row_w      = {1'b0, bus.row};
    tile_col   = wx / TW;
    lx         = wx % TW;
    tile_row   = row_w / TW;
    ly         = row_w % TW;
    oob_c      = row_w >= MAP_H;
    inner_c    = (lx >= TOK_LO) && (lx < TOK_HI) && (ly >= TOK_LO) && (ly < TOK_HI);
    map_addr_c = oob_c ? '0 : MAP_ADDR_W'(tile_row * MC + tile_col);
  end

  // Borrow bit of the 11-bit difference rejects pixels left of / above the sprite.
  always_comb begin
    hit_c  = 1'b0;
    slot_c = '0;
    u_c    = '0;
    v_c    = '0;
    dx     = '0;
    dy     = '0;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      dx = {1'b0, bus.col} - {1'b0, sprite_x_q[10*i +: 10]};
      dy = {1'b0, bus.row} - {1'b0, sprite_y_q[10*i +: 10]};
      if (!hit_c && sprite_en_q[i] && !dx[10] && (dx < SW) && !dy[10] && (dy < SW)) begin
        hit_c  = 1'b1;
        slot_c = SLOT_W'(i);
        u_c    = dx[UV_W-1:0];
        v_c    = dy[UV_W-1:0];
      end
    end
  end

  always_comb begin
    pal_c = '0;
    if (!oob2) begin
      case (bus.map_data)
        8'd1:    pal_c = 12'h09F;
        8'd2:    pal_c = 12'h843;
        8'd3:    pal_c = 12'h0F2;
        8'd4:    pal_c = inner2 ? 12'hFC0 : 12'h09F;
        default: pal_c = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v1 <= 1'b0; oob1 <= 1'b0; inner1 <= 1'b0; hit1 <= 1'b0;
      v2 <= 1'b0; oob2 <= 1'b0; inner2 <= 1'b0; hit2 <= 1'b0;
      v3 <= 1'b0; opq3 <= 1'b0; pal3 <= '0; spr3 <= '0;
      bus.map_addr  <= '0;
      bus.spr_addr  <= '0;
      bus.out_valid <= 1'b0;
      bus.red       <= '0;
      bus.green     <= '0;
      bus.blue      <= '0;
    end else begin
      v1           <= bus.pix_valid;
      oob1         <= oob_c;
      inner1       <= inner_c;
      hit1         <= hit_c;
      bus.map_addr <= map_addr_c;
      bus.spr_addr <= {slot_c, v_c, u_c};
      v2           <= v1;
      oob2         <= oob1;
      inner2       <= inner1;
      hit2         <= hit1;
      v3           <= v2;
      pal3         <= pal_c;
      spr3         <= bus.spr_data[11:0];
      opq3         <= hit2 & bus.spr_data[12];
      bus.out_valid <= v3;
      {bus.red, bus.green, bus.blue} <= v3 ? (opq3 ? spr3 : pal3) : 12'h000;
    end
  end
endmodule

// File: tb/tb_tile_sprite_renderer.sv
// Directed bench for tile_sprite_renderer: vector tables for palette and sprites,
// hand sequences for reset, frame latching and scroll (TILE_RENDERER_SCROLL_EN).
module tb_tile_sprite_renderer;
  localparam int NS  = 4;
  localparam int MAW = 8;
  localparam int SAW = 14;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  tile_sprite_renderer_if #(.NUM_SPRITES(NS), .MAP_ADDR_W(MAW), .SPR_ADDR_W(SAW)) bus ();

  tile_sprite_renderer #(
    .SCREEN_WIDTH(640), .SCREEN_HEIGHT(480), .TILE_W(40), .MAP_ROWS(12),
    .MAP_COLS(17), .NUM_SPRITES(NS), .SPRITE_W(42)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  logic [7:0]  map_mem [0:255];
  logic [12:0] spr_mem [0:16383];

  // Synchronous-read memories: data valid the cycle after the address.
  always @(posedge clk) begin
    bus.map_data <= map_mem[bus.map_addr];
    bus.spr_data <= spr_mem[bus.spr_addr];
  end

  logic [11:0] rgb_o;
  assign rgb_o = {bus.red, bus.green, bus.blue};

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [9:0]  row;
    logic [9:0]  col;
    logic        pv;
    logic        chk_map;
    logic [7:0]  exp_map;
    logic        chk_spr;
    logic [13:0] exp_spr;
    logic        exp_valid;
    logic [11:0] exp_rgb;
  } vec_t;

  function automatic vec_t mk(input string n, input int r, input int c, input bit pv,
                              input bit cm, input int em, input bit cs, input int es,
                              input bit ev, input int erg);
    vec_t v;
    v.name = n; v.row = 10'(r); v.col = 10'(c); v.pv = pv;
    v.chk_map = cm; v.exp_map = 8'(em); v.chk_spr = cs; v.exp_spr = 14'(es);
    v.exp_valid = ev; v.exp_rgb = 12'(erg);
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    bus.pix_valid = v.pv; bus.row = v.row; bus.col = v.col;
    @(posedge clk);
    @(negedge clk);
    bus.pix_valid = 1'b0;
    if (v.chk_map) chk({v.name, "/map_addr"}, 32'(bus.map_addr), 32'(v.exp_map));
    if (v.chk_spr) chk({v.name, "/spr_addr"}, 32'(bus.spr_addr), 32'(v.exp_spr));
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk({v.name, "/early_valid"}, 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk({v.name, "/out_valid"}, 32'(bus.out_valid), 32'(v.exp_valid));
    chk({v.name, "/rgb"}, 32'(rgb_o), 32'(v.exp_rgb));
  endtask

  task automatic set_frame(input logic [9:0] sc, input logic [3:0] en,
                           input logic [39:0] sx, input logic [39:0] sy);
    @(negedge clk);
    bus.frame_start = 1'b1; bus.scroll_x = sc; bus.sprite_en = en;
    bus.sprite_x = sx; bus.sprite_y = sy;
    @(posedge clk);
    @(negedge clk);
    bus.frame_start = 1'b0;
  endtask

  vec_t tv[$];
  vec_t sv[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) map_mem[i] = 8'd0;
    for (int i = 0; i < 16384; i++) spr_mem[i] = 13'd0;
    map_mem[0] = 8'd1;
    bus.pix_valid = 1'b1; bus.row = '0; bus.col = '0; bus.frame_start = 1'b0;
    bus.scroll_x = '0; bus.sprite_en = '0; bus.sprite_x = '0; bus.sprite_y = '0;

    // Reset held 4 cycles while pixels stream
    repeat (4) begin
      @(negedge clk);
      bus.col = bus.col + 10'd1;
    end
    @(negedge clk);
    chk("reset/rgb", 32'(rgb_o), 32'd0);
    chk("reset/out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset/map_addr", 32'(bus.map_addr), 32'd0);
    chk("reset/spr_addr", 32'(bus.spr_addr), 32'd0);
    reset_n = 1'b1;
    bus.pix_valid = 1'b0;
    run_vec(mk("first_pixel", 0, 0, 1, 1, 0, 0, 0, 1, 'h09F));

    // In-flight pixel discarded by reset
    @(negedge clk);
    bus.pix_valid = 1'b1; bus.row = 10'd0; bus.col = 10'd45;
    @(posedge clk);
    @(negedge clk);
    bus.pix_valid = 1'b0;
    chk("discard/map_addr_pre", 32'(bus.map_addr), 32'd1);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    chk("discard/map_addr", 32'(bus.map_addr), 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("discard/out_valid", 32'(bus.out_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end

    map_mem[0] = 8'd4;  map_mem[1] = 8'd9;  map_mem[2] = 8'd2;  map_mem[3] = 8'd3;
    map_mem[15] = 8'd2; map_mem[16] = 8'd3; map_mem[17] = 8'd1; map_mem[36] = 8'd2;
    map_mem[37] = 8'd1; map_mem[187] = 8'd3;

    tv.push_back(mk("tok_edge",      5,   5, 1, 1,   0, 0, 0, 1, 'h09F));
    tv.push_back(mk("tok_center",   20,  20, 1, 1,   0, 0, 0, 1, 'hFC0));
    tv.push_back(mk("tok_lo_corner",10,  10, 1, 1,   0, 0, 0, 1, 'hFC0));
    tv.push_back(mk("tok_row9",      9,  10, 1, 1,   0, 0, 0, 1, 'h09F));
    tv.push_back(mk("tok_hi_corner",29,  29, 1, 1,   0, 0, 0, 1, 'hFC0));
    tv.push_back(mk("tok_col30",    29,  30, 1, 1,   0, 0, 0, 1, 'h09F));
    tv.push_back(mk("code9",         0,  45, 1, 1,   1, 0, 0, 1, 'h000));
    tv.push_back(mk("block",         0,  85, 1, 1,   2, 0, 0, 1, 'h843));
    tv.push_back(mk("ground",        0, 125, 1, 1,   3, 0, 0, 1, 'h0F2));
    tv.push_back(mk("sky_row1",     45,   0, 1, 1,  17, 0, 0, 1, 'h09F));
    tv.push_back(mk("last_map_row",479,   0, 1, 1, 187, 0, 0, 1, 'h0F2));
    tv.push_back(mk("below_map",   480,   0, 1, 0,   0, 0, 0, 1, 'h000));
    tv.push_back(mk("blank_480",   480,   0, 0, 0,   0, 0, 0, 0, 'h000));
    tv.push_back(mk("blank_sky",    45,   0, 0, 0,   0, 0, 0, 0, 'h000));
    tv.push_back(mk("last_col",      0, 639, 1, 1,  15, 0, 0, 1, 'h843));
    foreach (tv[i]) run_vec(tv[i]);

    // Sprites: slot0 at (90,90), slot2 at (80,80), slots 1/3 disabled
    spr_mem[650]  = 13'h1F00; spr_mem[714]  = 13'h0ABC; spr_mem[9556] = 13'h10F0;
    spr_mem[8257] = 13'h1123; spr_mem[681]  = 13'h1456; spr_mem[2634] = 13'h1789;
    spr_mem[9492] = 13'h1ABC;
    set_frame(10'd0, 4'b0101, {10'd0, 10'd80, 10'd0, 10'd90}, {10'd0, 10'd80, 10'd0, 10'd90});

    sv.push_back(mk("spr0_opaque",   100, 100, 1, 1, 36, 1,  650, 1, 'hF00));
    sv.push_back(mk("spr0_transp",   101, 100, 1, 1, 36, 1,  714, 1, 'h843));
    sv.push_back(mk("spr2_only",      81,  81, 1, 1, 36, 1, 8257, 1, 'h123));
    sv.push_back(mk("spr0_right",    100, 131, 1, 1, 37, 1,  681, 1, 'h456));
    sv.push_back(mk("past_right",    100, 132, 1, 1, 37, 0,    0, 1, 'h09F));
    sv.push_back(mk("spr0_bottom",   131, 100, 1, 0,  0, 1, 2634, 1, 'h789));
    foreach (sv[i]) run_vec(sv[i]);

    // frame_start coincides with pixel P: P uses old slot0 x, P+1 the new one
    @(negedge clk);
    bus.pix_valid = 1'b1; bus.row = 10'd100; bus.col = 10'd100;
    bus.frame_start = 1'b1; bus.sprite_x = {10'd0, 10'd80, 10'd0, 10'd200};
    @(posedge clk);
    @(negedge clk);
    bus.frame_start = 1'b0;
    chk("latch/spr_addr_old", 32'(bus.spr_addr), 32'd650);
    @(posedge clk);
    @(negedge clk);
    bus.pix_valid = 1'b0;
    chk("latch/spr_addr_new", 32'(bus.spr_addr), 32'd9492);
    @(posedge clk);
    @(negedge clk);
    chk("latch/early_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("latch/p_valid", 32'(bus.out_valid), 32'd1);
    chk("latch/p_rgb", 32'(rgb_o), 32'hF00);
    @(posedge clk);
    @(negedge clk);
    chk("latch/p1_valid", 32'(bus.out_valid), 32'd1);
    chk("latch/p1_rgb", 32'(rgb_o), 32'hABC);

`ifdef TILE_RENDERER_SCROLL_EN
    set_frame(10'd660, 4'b0000, 40'd0, 40'd0);
    run_vec(mk("wrap_col20", 0, 20, 1, 1,  0, 0, 0, 1, 'h09F));
    run_vec(mk("wrap_col0",  0,  0, 1, 1, 16, 0, 0, 1, 'h0F2));
    run_vec(mk("wrap_col19", 0, 19, 1, 1, 16, 0, 0, 1, 'h0F2));
    @(negedge clk);
    bus.scroll_x = 10'd0;
    run_vec(mk("scroll_held", 0, 0, 1, 1, 16, 0, 0, 1, 'h0F2));
    set_frame(10'd40, 4'b0000, 40'd0, 40'd0);
    run_vec(mk("scroll40_col0", 0, 0, 1, 1, 1, 0, 0, 1, 'h000));
`else
    set_frame(10'd40, 4'b0000, 40'd0, 40'd0);
    run_vec(mk("noscroll_col0",  0,  0, 1, 1, 0, 0, 0, 1, 'h09F));
    run_vec(mk("noscroll_col45", 0, 45, 1, 1, 1, 0, 0, 1, 'h000));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
